// File: rtl/serial_add_seq.sv
// Sequencer wrapped around a bit-serial JK-carry adder. It loads two N-bit
// operands on start, shifts for N cycles, then holds the sum and carry-out.
module serial_add_seq #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         start,
  input  logic         abort,
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] b_in,
  output logic         busy,
  output logic         sft_en,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [N-1:0]   ra;
  logic [N-1:0]   rb;
  logic           carry;
  logic [CW-1:0]  cnt;

  logic           x;
  logic           y;
  logic           s;
  logic           carry_nxt;
  logic           last;
  logic           shift_go;

  // JK flip-flop update; J=K=1 cannot arise from J=x&y, K=~(x|y).
  function automatic logic jk_next(input logic q, input logic j, input logic k);
    return j | (q & ~k);
  endfunction

  function automatic logic sum_bit(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  assign x         = ra[0];
  assign y         = rb[0];
  assign s         = sum_bit(x, y, carry);
  assign carry_nxt = jk_next(carry, x & y, ~(x | y));
  assign last      = (cnt == LAST_CNT);
  assign shift_go  = (state == SHIFT) && !abort;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT: begin
        if (abort)     state_nxt = IDLE;
        else if (last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != IDLE);
    sft_en = (state == SHIFT);
    done   = (state == DONE);
  end

  // Operand/sum shift registers; the sum overwrites A as it shifts in from the top.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      ra    <= '0;
      rb    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (state == IDLE && start) begin
      ra    <= a_in;
      rb    <= b_in;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (shift_go) begin
      ra    <= {s, ra[N-1:1]};
      rb    <= {1'b0, rb[N-1:1]};
      carry <= carry_nxt;
      if (last) begin
        sum  <= {s, ra[N-1:1]};
        cout <= carry_nxt;
      end else begin
        cnt  <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed and random checks of serial_add_seq at N=8 and N=2.
module tb_serial_add_seq;
  localparam int N = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         clr_n;
  logic         start, abort;
  logic [N-1:0] a_in, b_in;
  logic         busy, sft_en, done, cout;
  logic [N-1:0] sum;

  logic         start2, abort2;
  logic [1:0]   a2, b2;
  logic         busy2, sft2, done2, cout2;
  logic [1:0]   sum2;

  int tests = 0;
  int fails = 0;

  serial_add_seq #(.N(N)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .abort(abort),
    .a_in(a_in), .b_in(b_in), .busy(busy), .sft_en(sft_en),
    .done(done), .sum(sum), .cout(cout)
  );

  serial_add_seq #(.N(2)) dut2 (
    .clk(clk), .clr_n(clr_n), .start(start2), .abort(abort2),
    .a_in(a2), .b_in(b2), .busy(busy2), .sft_en(sft2),
    .done(done2), .sum(sum2), .cout(cout2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full operation with per-cycle control checks; res = {cout, sum}.
  task automatic run_add(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [8:0] res);
    a_in = a; b_in = b; start = 1'b1;
    tick();
    start = 1'b0; a_in = ~a; b_in = ~b;
    for (int i = 0; i < N; i++) begin
      check({tag, "_sft_en"}, 32'(sft_en), 32'd1);
      check({tag, "_busy"},   32'(busy),   32'd1);
      check({tag, "_nodone"}, 32'(done),   32'd0);
      tick();
    end
    check({tag, "_done"},     32'(done),   32'd1);
    check({tag, "_sft_off"},  32'(sft_en), 32'd0);
    check({tag, "_busy_dn"},  32'(busy),   32'd1);
    check({tag, "_sum"},      32'(sum),    32'(res[7:0]));
    check({tag, "_cout"},     32'(cout),   32'(res[8]));
    tick();
    check({tag, "_idle"},     32'(busy),   32'd0);
    check({tag, "_done_1cy"}, 32'(done),   32'd0);
    check({tag, "_hold"},     32'(sum),    32'(res[7:0]));
  endtask

  initial begin
    logic [8:0] e8;
    logic [2:0] e2;
    bit         seen;

    clr_n = 1'b0; start = 1'b0; abort = 1'b0; a_in = '0; b_in = '0;
    start2 = 1'b0; abort2 = 1'b0; a2 = '0; b2 = '0;
    tick(); tick();
    check("rst_busy", 32'(busy),   32'd0);
    check("rst_sft",  32'(sft_en), 32'd0);
    check("rst_done", 32'(done),   32'd0);
    check("rst_sum",  32'(sum),    32'd0);
    check("rst_cout", 32'(cout),   32'd0);
    check("rst_busy2", 32'(busy2), 32'd0);
    clr_n = 1'b1;
    tick();

    run_add("a5a_3c", 8'h5A, 8'h3C, 9'h096);
    run_add("ff_01",  8'hFF, 8'h01, 9'h100);
    run_add("ff_ff",  8'hFF, 8'hFF, 9'h1FE);
    run_add("00_00",  8'h00, 8'h00, 9'h000);

    // start held high: second operation begins only at the first IDLE edge
    a_in = 8'h12; b_in = 8'h34; start = 1'b1;
    tick();
    a_in = 8'h01; b_in = 8'h02;
    repeat (N) tick();
    check("hold_done", 32'(done), 32'd1);
    check("hold_sum",  32'(sum),  32'h46);
    check("hold_cout", 32'(cout), 32'd0);
    tick();
    check("hold_idle", 32'(busy), 32'd0);
    tick();
    check("hold_restart", 32'(sft_en), 32'd1);
    start = 1'b0;
    repeat (N) tick();
    check("hold2_done", 32'(done), 32'd1);
    check("hold2_sum",  32'(sum),  32'h03);
    tick();

    // abort on the 4th SHIFT cycle
    a_in = 8'hAA; b_in = 8'h55; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("abort_pre", 32'(sft_en), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum",  32'(sum),  32'h03);
    check("abort_cout", 32'(cout), 32'd0);
    tick();
    check("abort_nodone", 32'(done), 32'd0);
    run_add("01_01", 8'h01, 8'h01, 9'h002);

    // reset in the 5th SHIFT cycle
    a_in = 8'hF0; b_in = 8'h0F; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("rst_mid_pre", 32'(sft_en), 32'd1);
    clr_n = 1'b0;
    tick();
    clr_n = 1'b1;
    check("rstm_busy", 32'(busy),   32'd0);
    check("rstm_sft",  32'(sft_en), 32'd0);
    check("rstm_done", 32'(done),   32'd0);
    check("rstm_sum",  32'(sum),    32'd0);
    check("rstm_cout", 32'(cout),   32'd0);
    run_add("80_80", 8'h80, 8'h80, 9'h100);

    // start and abort together in IDLE: start wins
    a_in = 8'h10; b_in = 8'h20; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("sa_sft", 32'(sft_en), 32'd1);
    repeat (N) tick();
    check("sa_done", 32'(done), 32'd1);
    check("sa_sum",  32'(sum),  32'h30);
    tick();

    // random back-to-back at N=8: each start issued in the cycle busy falls
    for (int v = 0; v < 500; v++) begin
      a_in = 8'($urandom); b_in = 8'($urandom);
      e8 = {1'b0, a_in} + {1'b0, b_in};
      start = 1'b1;
      tick();
      start = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < N + 3 && !seen; c++) begin
        tick();
        if (done) seen = 1'b1;
      end
      check("r8_done_seen", 32'(seen), 32'd1);
      check("r8_res", 32'({cout, sum}), 32'(e8));
      tick();
    end

    // random back-to-back at N=2
    for (int v = 0; v < 500; v++) begin
      a2 = 2'($urandom); b2 = 2'($urandom);
      e2 = {1'b0, a2} + {1'b0, b2};
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 6 && !seen; c++) begin
        tick();
        if (done2) seen = 1'b1;
      end
      check("r2_done_seen", 32'(seen), 32'd1);
      check("r2_res", 32'({cout2, sum2}), 32'(e2));
      tick();
      check("r2_idle", 32'(busy2), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
